// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings on the {S1,S0} select.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_DBL = 2'b11
  } op_t;

endpackage

// File: rtl/alu_pipe_param_if.sv
// Operand-source / result-sink bundle for alu_pipe_param; master drives operands and ready_in.
interface alu_pipe_param_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  op_t              op_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] result_out;
  logic             carry_out;
  logic             ovf_out;
  logic             zero_out;
  logic             valid_out;
  logic             ready_in;
  logic [CNT_W-1:0] op_count_out;

  modport master (
    output a_in, b_in, op_in, valid_in, ready_in,
    input  ready_out, result_out, carry_out, ovf_out, zero_out, valid_out, op_count_out
  );

  modport slave (
    input  a_in, b_in, op_in, valid_in, ready_in,
    output ready_out, result_out, carry_out, ovf_out, zero_out, valid_out, op_count_out
  );

endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU (invert, add, subtract, double) with carry/borrow and overflow.
// Define ALU_SAT_EN for unsigned saturation; otherwise results wrap modulo 2^WIDTH.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] wide;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    wide  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_INV: wide = {1'b0, ~a};
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra bit of an unsigned subtract is set exactly when a < b.
        wide  = {1'b0, a} - {1'b0, b};
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DBL: begin
        wide  = {a, 1'b0};
        carry = a[WIDTH-1];
        ovf   = a[WIDTH-1] ^ a[WIDTH-2];
      end
    endcase

    result = wide[WIDTH-1:0];
`ifdef ALU_SAT_EN
    // Flags still describe the raw event; only the result is clamped.
    if (carry) result = (op == OP_SUB) ? '0 : '1;
`endif
  end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage valid/ready ALU pipeline (operand stage, result stage) with a completed-op counter.
// ALU_SAT_EN (see alu_core) selects saturating results; default build wraps.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  alu_pipe_param_if.slave   bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;

  logic             adv;
  logic             in_xfer;
  logic             out_xfer;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;

  assign adv           = !bus.valid_out || bus.ready_in;
  assign bus.ready_out = !s1_valid || adv;
  assign in_xfer       = bus.valid_in && bus.ready_out;
  assign out_xfer      = bus.valid_out && bus.ready_in;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  // NOTE: operand registers are reset too, so nothing stale is ever visible after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_INV;
    end else if (in_xfer) begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      s1_valid <= 1'b1;
      s1_a     <= bus.a_in;
      s1_b     <= bus.b_in;
      s1_op    <= bus.op_in;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.valid_out  <= 1'b0;
      bus.result_out <= '0;
      bus.carry_out  <= 1'b0;
      bus.ovf_out    <= 1'b0;
      bus.zero_out   <= 1'b0;
    end else if (adv) begin
      bus.valid_out <= s1_valid;
      if (s1_valid) begin
        bus.result_out <= core_result;
        bus.carry_out  <= core_carry;
        bus.ovf_out    <= core_ovf;
        bus.zero_out   <= (core_result == '0);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.op_count_out <= '0;
    end else if (out_xfer) begin
      bus.op_count_out <= bus.op_count_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Self-checking bench for alu_pipe_param (WIDTH=4): directed table, stall/reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_alu_pipe_param;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_param_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_pipe_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int       op;
    int       a;
    int       b;
    logic [3:0] r;
    logic     c;
    logic     o;
    logic     z;
  } vec_t;

  vec_t tbl [12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.result_out, bus.carry_out, bus.ovf_out, bus.zero_out};
  endfunction

  // Reference: plain integer arithmetic, signed overflow as "true result out of signed range".
  function automatic logic [6:0] model(input int op, input int a, input int b);
    int m, h, sa, sb, raw, sraw, r;
    logic c, o;
    logic [3:0] r4;
    m  = 1 << W;
    h  = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    c  = 1'b0;
    o  = 1'b0;
    case (op)
      0: raw = m - 1 - a;
      1: begin raw = a + b; c = (raw >= m); sraw = sa + sb; o = (sraw < -h) || (sraw >= h); end
      2: begin raw = a - b; c = (a < b);    sraw = sa - sb; o = (sraw < -h) || (sraw >= h); end
      default: begin raw = 2 * a; c = (raw >= m); sraw = 2 * sa; o = (sraw < -h) || (sraw >= h); end
    endcase
    r = ((raw % m) + m) % m;
`ifdef ALU_SAT_EN
    if (c) r = (op == 2) ? 0 : m - 1;
`endif
    r4 = r[3:0];
    return {r4, c, o, (r == 0)};
  endfunction

  task automatic drive(input bit v, input int op, input int a, input int b, input bit rdy);
    bus.valid_in = v;
    bus.op_in    = op_t'(op[1:0]);
    bus.a_in     = a[W-1:0];
    bus.b_in     = b[W-1:0];
    bus.ready_in = rdy;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " valid_out"}, bus.valid_out, 0);
    check({tag, " ready_out"}, bus.ready_out, 1);
    check({tag, " flags+result"}, outs(), 0);
    check({tag, " op_count"}, bus.op_count_out, 0);
  endtask

  task automatic pulse_reset();
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s5_ops [6][3];
    int sent, got, exp_cnt;
    bit saw_low, held_valid, rdy, v;
    logic [6:0] held;
    int op, a, b;
    logic [6:0] q [$];

    tbl[0]  = '{0, 2, 0, 4'd13, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{0, 15, 0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1, 3, 5, 4'd8, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1, 2, 10, 4'd12, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2, 13, 2, 4'd11, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2, 6, 4, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3, 5, 0, 4'd10, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{3, 7, 0, 4'd14, 1'b0, 1'b1, 1'b0};
`ifdef ALU_SAT_EN
    tbl[4]  = '{1, 9, 9, 4'd15, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2, 2, 13, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{3, 12, 0, 4'd15, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1, 15, 1, 4'd15, 1'b1, 1'b0, 1'b0};
`else
    tbl[4]  = '{1, 9, 9, 4'd2, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2, 2, 13, 4'd5, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3, 12, 0, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1, 15, 1, 4'd0, 1'b1, 1'b0, 1'b1};
`endif
    s5_ops = '{'{1, 1, 1}, '{1, 2, 3}, '{2, 7, 1}, '{0, 3, 0}, '{3, 4, 0}, '{1, 9, 2}};

    // Power-on reset state
    drive(0, 0, 0, 0, 1);
    #12;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: one op at a time, checking two-cycle latency
    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].op, tbl[i].a, tbl[i].b, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      #1 check($sformatf("vec%0d early valid", i), bus.valid_out, 0);
      @(negedge clk);
      #1 check($sformatf("vec%0d valid", i), bus.valid_out, 1);
      check($sformatf("vec%0d {r,c,o,z}", i), outs(), {tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].z});
      @(negedge clk);
    end

    // Six back-to-back ops with the sink stalled on cycles 3-5
    pulse_reset();
    sent = 0; got = 0; saw_low = 0; held_valid = 0; held = '0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      rdy = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) drive(1, s5_ops[sent][0], s5_ops[sent][1], s5_ops[sent][2], rdy);
      else          drive(0, 0, 0, 0, rdy);
      #1;
      if (held_valid)
        check($sformatf("stall hold c%0d", cyc), {bus.valid_out, outs()}, {1'b1, held});
      held_valid = bus.valid_out && !rdy;
      held       = outs();
      if (bus.valid_out && rdy) begin
        check($sformatf("stream out%0d", got), outs(),
              model(s5_ops[got][0], s5_ops[got][1], s5_ops[got][2]));
        got++;
      end
      if (!bus.ready_out) saw_low = 1;
      if (bus.valid_in && bus.ready_out) sent++;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1);
    check("stream results", got, 6);
    check("stream ready_out low seen", saw_low, 1);
    check("stream op_count", bus.op_count_out, 6);

    // Reset with two ops in flight
    drive(1, 1, 3, 4, 0);
    @(negedge clk);
    drive(1, 1, 5, 6, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1 check("inflight valid_out", bus.valid_out, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    #1 check("post-reset early valid", bus.valid_out, 0);
    @(negedge clk);
    #1 check("post-reset valid", bus.valid_out, 1);
    check("post-reset 1+1", outs(), model(1, 1, 1));
    @(negedge clk);
    #1 check("post-reset op_count", bus.op_count_out, 1);
    check("post-reset no stale op", bus.valid_out, 0);

    // Randomized stream against the scoreboard; long enough to wrap the counter
    exp_cnt = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 3);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      drive(v, op, a, b, rdy);
      #1;
      check("rand op_count", bus.op_count_out, exp_cnt % 256);
      check("rand ready_out", bus.ready_out, (q.size() < 2) || rdy);
      if (bus.valid_out) begin
        if (q.size() == 0) check("rand spurious valid_out", bus.valid_out, 0);
        else if (rdy) begin
          check($sformatf("rand result c%0d", cyc), outs(), q.pop_front());
          exp_cnt++;
        end
      end
      if (v && bus.ready_out) q.push_back(model(op, a, b));
      @(negedge clk);
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      if (bus.valid_out) begin
        check("drain result", outs(), q.pop_front());
        exp_cnt++;
      end
      @(negedge clk);
    end
    check("drain empty", q.size(), 0);
    #1 check("drain op_count", bus.op_count_out, exp_cnt % 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
